// File: rtl/centering_unit.sv
// Mean-removal stage: accumulates one pass of samples, derives per-channel means,
// then streams the replayed samples back out with the mean subtracted and saturated.
module centering_unit #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 16,
  parameter int N_SAMPLES = 128,
  parameter int LOG2_N    = 7
) (
  input  logic                     CLK_cen,
  input  logic                     RST_cen,
  input  logic                     GO_cen,
  input  logic                     data_valid,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  output logic [N_CH*DATA_W-1:0]   cen_out,
  output logic                     cen_valid,
  output logic [N_CH*DATA_W-1:0]   mean_out,
  output logic                     CEN_busy,
  output logic                     cen_done
);

  localparam int ACC_W = DATA_W + LOG2_N;

  typedef enum logic [2:0] {IDLE, SUM, DIV, SUB, DONE} state_t;

  state_t                   state, next_state;
  logic [LOG2_N-1:0]        cnt;
  logic signed [ACC_W-1:0]  acc [N_CH];
  logic [N_CH*DATA_W-1:0]   mean_next, sub_next;
  logic                     last;

  // cnt is exactly LOG2_N bits, so all-ones marks sample N_SAMPLES-1 and the
  // increment wraps it back to zero for the next pass.
  assign last = data_valid && (&cnt);

  always_comb begin
    next_state = state;
    if (!GO_cen) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = SUM;
        SUM:     if (last) next_state = DIV;
        DIV:     next_state = SUB;
        SUB:     if (last) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_cen or posedge RST_cen) begin
    if (RST_cen) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W:0]         d;
    mean_next = '0;
    sub_next  = '0;
    sh        = '0;
    d         = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sh = acc[c] >>> LOG2_N;
      mean_next[c*DATA_W +: DATA_W] = sh[DATA_W-1:0];
      d = {data_in[c*DATA_W+DATA_W-1], data_in[c*DATA_W +: DATA_W]}
        - {mean_out[c*DATA_W+DATA_W-1], mean_out[c*DATA_W +: DATA_W]};
      // Differing top two bits of the DATA_W+1 result mean it left the DATA_W range.
      if (d[DATA_W] != d[DATA_W-1])
        sub_next[c*DATA_W +: DATA_W] = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                 : {1'b0, {(DATA_W-1){1'b1}}};
      else
        sub_next[c*DATA_W +: DATA_W] = d[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK_cen or posedge RST_cen) begin
    if (RST_cen) begin
      for (int unsigned c = 0; c < N_CH; c++) acc[c] <= '0;
      cnt       <= '0;
      mean_out  <= '0;
      cen_out   <= '0;
      cen_valid <= 1'b0;
      CEN_busy  <= 1'b0;
      cen_done  <= 1'b0;
    end else begin
      cen_valid <= 1'b0;
      cen_done  <= 1'b0;
      CEN_busy  <= (next_state == SUM) || (next_state == DIV) || (next_state == SUB);
      case (state)
        IDLE: begin
          if (GO_cen) begin
            for (int unsigned c = 0; c < N_CH; c++) acc[c] <= '0;
            cnt <= '0;
          end
        end
        SUM: begin
          if (data_valid) begin
            for (int unsigned c = 0; c < N_CH; c++)
              acc[c] <= acc[c] + {{LOG2_N{data_in[c*DATA_W+DATA_W-1]}},
                                  data_in[c*DATA_W +: DATA_W]};
            cnt <= cnt + 1'b1;
          end
        end
        DIV: mean_out <= mean_next;
        SUB: begin
          if (data_valid) begin
            cen_out   <= sub_next;
            cen_valid <= 1'b1;
            cnt       <= cnt + 1'b1;
            cen_done  <= last && GO_cen;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centering_unit.sv
// Directed bench for centering_unit: full runs, stalls, saturation, abort and async reset.
module tb_centering_unit;

  logic        clk = 1'b0;
  logic        rst, go, dv;
  logic [63:0] din;
  logic [63:0] cen_out, mean_out;
  logic        cen_valid, busy, cen_done;

  int          passed = 0;
  int          total  = 0;
  int          done_cnt = 0;
  logic [63:0] got[$];

  always #5 clk = ~clk;

  centering_unit #(.N_CH(4), .DATA_W(16), .N_SAMPLES(128), .LOG2_N(7)) dut (
    .CLK_cen(clk), .RST_cen(rst), .GO_cen(go), .data_valid(dv), .data_in(din),
    .cen_out(cen_out), .cen_valid(cen_valid), .mean_out(mean_out),
    .CEN_busy(busy), .cen_done(cen_done)
  );

  always @(posedge clk) begin
    #1;
    if (cen_valid) got.push_back(cen_out);
    if (cen_done) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] pack4(int a, int b, int c, int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] sample(int t, int pass, int i);
    case (t)
      1:       return pack4(100, 100, 100, 100);
      2:       return pack4((i % 2 == 0) ? 1000 : -1000, i, 0, 0);
      3:       return pack4((pass == 2 || i == 127) ? 32767 : -32768, 0, 0, 0);
      default: return pack4(5000, -7000, 3000, 12000);
    endcase
  endfunction

  function automatic logic [63:0] exp_mean(int t);
    case (t)
      1:       return pack4(100, 100, 100, 100);
      2:       return pack4(0, 63, 0, 0);
      default: return pack4(-32257, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [63:0] exp_cen(int t, int i);
    case (t)
      1:       return 64'd0;
      2:       return pack4((i % 2 == 0) ? 1000 : -1000, i - 63, 0, 0);
      default: return pack4(32767, 0, 0, 0);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] d);
    @(negedge clk);
    dv  = v;
    din = d;
  endtask

  task automatic gap(input bit gaps);
    if (gaps)
      while ($urandom_range(0, 1) == 1) drive(1'b0, {$urandom, $urandom});
  endtask

  task automatic run(input int t, input bit gaps);
    int d0;
    got.delete();
    d0 = done_cnt;
    @(negedge clk);
    go = 1'b1;
    dv = 1'b0;
    @(negedge clk);
    chk($sformatf("busy_start_t%0d", t), {63'd0, busy}, 64'd1);
    for (int i = 0; i < 128; i++) begin
      gap(gaps);
      drive(1'b1, sample(t, 1, i));
    end
    drive(1'b0, 64'd0);
    @(negedge clk);
    chk($sformatf("mean_t%0d", t), mean_out, exp_mean(t));
    chk($sformatf("busy_sub_t%0d", t), {63'd0, busy}, 64'd1);
    for (int i = 0; i < 128; i++) begin
      gap(gaps);
      drive(1'b1, sample(t, 2, i));
    end
    drive(1'b0, 64'd0);
    chk($sformatf("done_pulse_t%0d", t), {63'd0, cen_done}, 64'd1);
    chk($sformatf("last_valid_t%0d", t), {63'd0, cen_valid}, 64'd1);
    chk($sformatf("busy_done_t%0d", t), {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk($sformatf("done_end_t%0d", t), {63'd0, cen_done}, 64'd0);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("cen_count_t%0d", t), 64'(got.size()), 64'd128);
    chk($sformatf("done_count_t%0d", t), 64'(done_cnt - d0), 64'd1);
    for (int i = 0; i < 128 && i < got.size(); i++)
      chk($sformatf("cen_t%0d_%0d", t, i), got[i], exp_cen(t, i));
  endtask

  initial begin
    int d0;
    rst = 1'b0; go = 1'b0; dv = 1'b0; din = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_cen_out", cen_out, 64'd0);
    chk("rst_mean_out", mean_out, 64'd0);
    chk("rst_flags", {61'd0, cen_valid, busy, cen_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(1, 1'b0);
    run(2, 1'b0);
    run(3, 1'b0);
    run(2, 1'b1);

    // Abort after 60 SUM samples, then a clean run must give untouched means.
    @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 60; i++) drive(1'b1, sample(5, 1, i));
    @(negedge clk);
    go = 1'b0;
    dv = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_state", 64'(dut.state), 64'd0);
    run(2, 1'b0);

    // Asynchronous reset part-way through the SUB pass.
    d0 = done_cnt;
    @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 128; i++) drive(1'b1, sample(2, 1, i));
    drive(1'b0, 64'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, sample(2, 2, i));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cen_out", cen_out, 64'd0);
    chk("arst_mean_out", mean_out, 64'd0);
    chk("arst_flags", {61'd0, cen_valid, busy, cen_done}, 64'd0);
    chk("arst_state", 64'(dut.state), 64'd0);
    go = 1'b0;
    dv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("arst_idle_busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
